// File: rtl/serial_addsub.sv
// Chunk-serial adder/subtractor: CHUNK bits of x and y per clock, LSB chunk first,
// with optional signed saturation. Results and flags update only on the completing edge.
module serial_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic             sat,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, acc_q, acc_d, s_q, s_d;
  logic             op_q, op_d, sat_q, sat_d, carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;

  logic [CHUNK-1:0] x_chunk, y_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] acc_full, sat_val, result;
  logic             ovf_raw;

  always_comb begin
    x_chunk   = x_q[int'(cnt_q)*CHUNK +: CHUNK];
    y_chunk   = y_q[int'(cnt_q)*CHUNK +: CHUNK] ^ {CHUNK{op_q}};
    chunk_sum = {1'b0, x_chunk} + {1'b0, y_chunk} + (CHUNK+1)'(carry_q);
    acc_full  = acc_q;
    acc_full[int'(cnt_q)*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    // Sign-based overflow test is equivalent to carry-in(MSB) xor carry-out(MSB).
    ovf_raw   = (x_q[WIDTH-1] == (y_q[WIDTH-1] ^ op_q)) && (acc_full[WIDTH-1] != x_q[WIDTH-1]);
    sat_val   = x_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    result    = (sat_q && ovf_raw) ? sat_val : acc_full;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    op_d    = op_q;
    sat_d   = sat_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          x_d     = x;
          y_d     = y;
          op_d    = op;
          sat_d   = sat;
          carry_d = op;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d   = acc_full;
        carry_d = chunk_sum[CHUNK];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          s_d     = result;
          cout_d  = chunk_sum[CHUNK];
          ovf_d   = ovf_raw;
          zero_d  = (result == '0);
          neg_d   = result[WIDTH-1];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      op_q    <= 1'b0;
      sat_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      sat_q   <= sat_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;
  assign neg  = neg_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: vector table through a scoreboard on a 16/4 instance,
// plus hand-written ignore-start, back-to-back, reset-abort and a 5/1 instance.
module tb_serial_addsub;

  localparam int N = 4;

  typedef struct {
    logic        op, sat;
    logic [15:0] x, y, s;
    logic        cout, ovf, zero, neg;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, op = 1'b0, sat = 1'b0;
  logic [15:0] x = '0, y = '0;
  logic        busy, done, cout, ovf, zero, neg;
  logic [15:0] s;

  logic        start5 = 1'b0, op5 = 1'b0, sat5 = 1'b0;
  logic [4:0]  x5 = '0, y5 = '0;
  logic        busy5, done5, cout5, ovf5, zero5, neg5;
  logic [4:0]  s5;

  int          checks = 0;
  int          errors = 0;
  vec_t        sb[$];
  vec_t        vecs[10];
  logic [15:0] prev_s = '0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .sat(sat), .x(x), .y(y),
    .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
  );

  serial_addsub #(.WIDTH(5), .CHUNK(1)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .op(op5), .sat(sat5), .x(x5), .y(y5),
    .busy(busy5), .done(done5), .s(s5), .cout(cout5), .ovf(ovf5), .zero(zero5), .neg(neg5)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest pushed expectation.
  always @(negedge clk) begin
    vec_t e;
    if (!rst_n) begin
      prev_s = '0;
    end else begin
      if (busy) chk("hold_s", s, prev_s);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          $display("op=%0d sat=%0d x=%h y=%h -> s=%h cout=%0d ovf=%0d zero=%0d neg=%0d",
                   e.op, e.sat, e.x, e.y, s, cout, ovf, zero, neg);
          chk("s", s, e.s);
          chk("cout", cout, e.cout);
          chk("ovf", ovf, e.ovf);
          chk("zero", zero, e.zero);
          chk("neg", neg, e.neg);
        end
        prev_s = s;
      end
    end
  end

  task automatic drive(input vec_t v, input bit expect_result);
    op = v.op; sat = v.sat; x = v.x; y = v.y; start = 1'b1;
    @(posedge clk);
    if (expect_result) sb.push_back(v);
    #1 start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 50) begin
      @(posedge clk);
      #1 cyc++;
    end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic run5(input logic o, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] es, input logic ec, input logic eo, input logic ez);
    int cyc;
    op5 = o; x5 = a; y5 = b; start5 = 1'b1;
    @(posedge clk);
    #1 start5 = 1'b0;
    cyc = 0;
    while (!done5 && cyc < 50) begin
      @(posedge clk);
      #1 cyc++;
    end
    $display("w5 op=%0d x=%0d y=%0d -> s=%b cout=%0d ovf=%0d zero=%0d cycles=%0d",
             o, a, b, s5, cout5, ovf5, zero5, cyc);
    chk("w5_latency", cyc, 5);
    chk("w5_s", s5, es);
    chk("w5_cout", cout5, ec);
    chk("w5_ovf", ovf5, eo);
    chk("w5_zero", zero5, ez);
  endtask

  initial begin
    int   cyc;
    vec_t va, vb;
    vecs[0] = '{1'b0, 1'b0, 16'h0007, 16'h0008, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 16'h8000, 16'h0001, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1};

    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_s", s, 16'h0);
    chk("rst_flags", {cout, ovf, zero, neg}, 4'b0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First vector is issued straight out of reset.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i], 1'b1);
      wait_done(cyc);
      chk("latency", cyc, N);
      chk("busy_at_done", busy, 1'b0);
      @(posedge clk);
      #1 chk("done_one_cycle", done, 1'b0);
    end

    // Start during RUN must be ignored.
    va = '{1'b0, 1'b0, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0};
    drive(va, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    op = 1'b1; x = 16'h0100; y = 16'h0100; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc);
    chk("ignored_start_latency", cyc, 1);
    repeat (6) begin @(posedge clk); #1; end

    // Back-to-back: new start while in DONE.
    va = '{1'b0, 1'b0, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0};
    vb = '{1'b1, 1'b0, 16'h0010, 16'h0020, 16'hFFF0, 1'b0, 1'b0, 1'b0, 1'b1};
    drive(va, 1'b1);
    wait_done(cyc);
    chk("b2b_first_latency", cyc, N);
    drive(vb, 1'b1);
    wait_done(cyc);
    chk("b2b_second_latency", cyc, N);

    // Reset mid-RUN aborts the operation.
    va = '{1'b0, 1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0};
    drive(va, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_s", s, 16'h0);
    chk("abort_flags", {cout, ovf, zero, neg}, 4'b0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    chk("abort_no_done", done, 1'b0);
    vb = '{1'b0, 1'b0, 16'h0100, 16'h0023, 16'h0123, 1'b0, 1'b0, 1'b0, 1'b0};
    drive(vb, 1'b1);
    wait_done(cyc);
    chk("post_abort_latency", cyc, N);

    // Narrow instance, one bit per clock.
    run5(1'b0, 5'd15, 5'd15, 5'b11110, 1'b0, 1'b1, 1'b0);
    run5(1'b1, 5'd15, 5'd15, 5'b00000, 1'b1, 1'b0, 1'b1);

    repeat (4) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
